prio_enc_arb: RTL and testbench

Registered, handshaked successor to the combinational priority encoder. It latches N = 2**OUTW request lines into sticky pending bits and selects one eligible index per transaction. Selection is either fixed priority (lowest index wins) or round-robin. The chosen index is presented on a valid/ready output, so a downstream consumer (interrupt dispatcher, DMA channel scheduler) can take one index at a time.

---
 rtl/prio_enc_arb.sv | 115 +++++++++++
 tb/tb_prio_enc_arb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_arb.sv
// Registered priority encoder / arbiter: sticky pending bits, fixed or round-robin
// selection, and one granted index at a time on a valid/ready output.
module prio_enc_arb #(
   parameter int unsigned OUTW = 4,
   parameter int unsigned RR   = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [(1 << OUTW)-1:0]   req,
   input  logic [(1 << OUTW)-1:0]   mask,
   input  logic                     clr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUTW-1:0]          out_idx,
   output logic [(1 << OUTW)-1:0]   pend
);

   localparam int unsigned N = 1 << OUTW;

   logic [N-1:0]    pend_q, pend_d;
   logic            out_valid_q, out_valid_d;
   logic [OUTW-1:0] out_idx_q, out_idx_d;
   logic [OUTW-1:0] ptr_c;
   logic            hs_c;
   logic            load_c;
   logic [N-1:0]    grant_oh_c;
   logic [N-1:0]    elig_c;
   logic [OUTW-1:0] sel_idx_c;
   logic            sel_found_c;
   logic [OUTW-1:0] cand_c;

   assign hs_c       = out_valid_q & out_ready;
   assign grant_oh_c = hs_c ? (N'(1) << out_idx_q) : '0;
   assign elig_c     = pend_q & mask & ~grant_oh_c;
   assign load_c     = clr | ~out_valid_q | hs_c;

   // Scan from the pointer with wrap; a zero pointer gives plain lowest-index priority.
   always_comb begin
      sel_found_c = 1'b0;
      sel_idx_c   = '0;
      cand_c      = '0;
      for (int unsigned off = 0; off < N; off++) begin
         cand_c = ptr_c + OUTW'(off);
         if (!sel_found_c && elig_c[cand_c]) begin
            sel_found_c = 1'b1;
            sel_idx_c   = cand_c;
         end
      end
   end

   // Pending bits: a new request wins over the clear from a same-cycle grant.
   always_comb begin
      pend_d = pend_q;
      if (clr) begin
         pend_d = '0;
      end else begin
         pend_d = req | (pend_q & ~grant_oh_c);
      end
   end

   // Presented grant is frozen while stalled; reloads on clear, idle, or handshake.
   always_comb begin
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      if (load_c) begin
         out_valid_d = ~clr & sel_found_c;
         if (sel_found_c) begin
            out_idx_d = sel_idx_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q      <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
      end else begin
         pend_q      <= pend_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
      end
   end

   if (RR != 0) begin : g_rr
      logic [OUTW-1:0] ptr_q, ptr_d;

      // Rotate past the index just accepted so it becomes lowest priority.
      always_comb begin
         ptr_d = ptr_q;
         if (clr) begin
            ptr_d = '0;
         end else if (hs_c) begin
            ptr_d = out_idx_q + OUTW'(1);
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            ptr_q <= '0;
         end else begin
            ptr_q <= ptr_d;
         end
      end

      assign ptr_c = ptr_q;
   end else begin : g_fixed
      assign ptr_c = '0;
   end

   assign pend      = pend_q;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_prio_enc_arb.sv
// Directed bench for prio_enc_arb: a fixed-priority instance (OUTW=3) and a
// round-robin instance (OUTW=2) driven from one sequence with hand-computed expectations.
module tb_prio_enc_arb;

   logic       clk;
   logic       rst_n;

   logic [7:0] req0, mask0, pend0;
   logic       clr0, ready0, valid0;
   logic [2:0] idx0;

   logic [3:0] req1, mask1, pend1;
   logic       clr1, ready1, valid1;
   logic [1:0] idx1;

   int n_chk;
   int n_err;

   prio_enc_arb #(.OUTW(3), .RR(0)) u_fix (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req0),
      .mask      (mask0),
      .clr       (clr0),
      .out_valid (valid0),
      .out_ready (ready0),
      .out_idx   (idx0),
      .pend      (pend0)
   );

   prio_enc_arb #(.OUTW(2), .RR(1)) u_rr (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req1),
      .mask      (mask1),
      .clr       (clr1),
      .out_valid (valid1),
      .out_ready (ready1),
      .out_idx   (idx1),
      .pend      (pend1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_err  = 0;
      rst_n  = 1'b0;
      req0   = '0; mask0 = 8'hFF; clr0 = 1'b0; ready0 = 1'b1;
      req1   = '0; mask1 = 4'hF;  clr1 = 1'b0; ready1 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(valid0), 32'd0);
      check("rst_pend",  32'(pend0),  32'd0);
      check("rst_idx",   32'(idx0),   32'd0);
      check("rst_rr_valid", 32'(valid1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Fixed order 2,5,7 from a single pulse
      req0 = 8'hA4;
      step();
      check("fo_pend0",  32'(pend0),  32'hA4);
      check("fo_valid0", 32'(valid0), 32'd0);
      req0 = 8'h00;
      step();
      check("fo_idx2",   32'(idx0),   32'd2);
      check("fo_val2",   32'(valid0), 32'd1);
      check("fo_pendA4", 32'(pend0),  32'hA4);
      step();
      check("fo_idx5",   32'(idx0),   32'd5);
      check("fo_pendA0", 32'(pend0),  32'hA0);
      step();
      check("fo_idx7",   32'(idx0),   32'd7);
      check("fo_pend80", 32'(pend0),  32'h80);
      step();
      check("fo_pend00", 32'(pend0),  32'h00);
      check("fo_idle",   32'(valid0), 32'd0);

      // Hold under backpressure
      ready0 = 1'b0;
      req0   = 8'h40;
      step();
      req0 = 8'h00;
      step();
      check("bp_idx6",  32'(idx0),   32'd6);
      check("bp_val6",  32'(valid0), 32'd1);
      req0 = 8'h02;
      step();
      req0 = 8'h00;
      step();
      check("bp_hold6", 32'(idx0),   32'd6);
      check("bp_pend42", 32'(pend0), 32'h42);
      ready0 = 1'b1;
      step();
      ready0 = 1'b0;
      check("bp_idx1",  32'(idx0),   32'd1);
      check("bp_val1",  32'(valid0), 32'd1);
      check("bp_pend02", 32'(pend0), 32'h02);
      step();
      check("bp_stall1", 32'(idx0),  32'd1);
      ready0 = 1'b1;
      step();
      check("bp_pend00", 32'(pend0),  32'h00);
      check("bp_idle",   32'(valid0), 32'd0);

      // Masked channel accumulates but is not granted until unmasked
      mask0 = 8'hF7;
      req0  = 8'h09;
      step();
      req0 = 8'h00;
      step();
      check("mk_idx0",  32'(idx0),   32'd0);
      step();
      check("mk_pend08", 32'(pend0), 32'h08);
      check("mk_idle",  32'(valid0), 32'd0);
      step();
      check("mk_still_idle", 32'(valid0), 32'd0);
      mask0 = 8'hFF;
      step();
      check("mk_idx3",  32'(idx0),   32'd3);
      check("mk_val3",  32'(valid0), 32'd1);
      step();
      check("mk_pend00", 32'(pend0), 32'h00);

      // clr beats a simultaneous request
      ready0 = 1'b0;
      req0   = 8'hFF;
      step();
      req0 = 8'h00;
      step();
      check("cl_pendFF", 32'(pend0),  32'hFF);
      check("cl_val",    32'(valid0), 32'd1);
      clr0 = 1'b1;
      req0 = 8'h10;
      step();
      clr0 = 1'b0;
      req0 = 8'h00;
      check("cl_pend00", 32'(pend0),  32'h00);
      check("cl_valid0", 32'(valid0), 32'd0);
      ready0 = 1'b1;

      // Round-robin with all requests held
      req1 = 4'hF;
      step();
      check("rr_val_first", 32'(valid1), 32'd0);
      for (int k = 0; k < 6; k++) begin
         step();
         check("rr_seq",  32'(idx1),   32'(k % 4));
         check("rr_val",  32'(valid1), 32'd1);
         check("rr_pend", 32'(pend1),  32'hF);
      end
      // Pointer is now 1; clr must reset it so bits {0,3} pick 0, not 3
      req1   = 4'h0;
      ready1 = 1'b0;
      clr1   = 1'b1;
      step();
      clr1 = 1'b0;
      check("rr_clr_pend",  32'(pend1),  32'h0);
      check("rr_clr_valid", 32'(valid1), 32'd0);
      req1 = 4'b1001;
      step();
      req1 = 4'h0;
      step();
      check("rr_ptr0_idx", 32'(idx1),   32'd0);
      check("rr_ptr0_val", 32'(valid1), 32'd1);
      ready1 = 1'b1;
      step();
      check("rr_next3", 32'(idx1), 32'd3);
      step();
      check("rr_drain", 32'(valid1), 32'd0);

      // Async reset between edges drops a presented grant
      ready0 = 1'b0;
      req0   = 8'h20;
      step();
      req0 = 8'h00;
      step();
      check("ar_idx5", 32'(idx0), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", 32'(valid0), 32'd0);
      check("ar_pend",  32'(pend0),  32'h00);
      check("ar_idx",   32'(idx0),   32'd0);
      @(posedge clk);
      #2;
      rst_n  = 1'b1;
      ready0 = 1'b1;
      req0   = 8'h10;
      step();
      req0 = 8'h00;
      check("ar_pend10", 32'(pend0),  32'h10);
      check("ar_novalid", 32'(valid0), 32'd0);
      step();
      check("ar_idx4", 32'(idx0),   32'd4);
      check("ar_val4", 32'(valid0), 32'd1);
      step();
      check("ar_done", 32'(valid0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
